// File: rtl/cpu_clk_pkg.sv
// Shared run-mode and FSM-state encodings for the CPU step controller.
// Pure type/helper package; no timing or flow-control behaviour of its own.
// Included by the controller top and its debounce sub-block.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        HALT = 2'b00,
        STEP = 2'b01,
        SLOW = 2'b10,
        FAST = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        HALTED  = 2'b00,
        RUNNING = 2'b01,
        BREAK   = 2'b10
    } state_t;

    // SLOW and FAST are the only modes that free-run the CPU.
    function automatic logic mode_runs(input mode_t m);
        return (m == SLOW) || (m == FAST);
    endfunction

endpackage

// File: rtl/step_debounce.sv
// Step button conditioner: 2-flop synchronizer, level debouncer, rising-edge pulse.
// Latency: press_o rises 2 + DEBOUNCE_CYCLES cycles after the button settles high.
// No backpressure: press_o is a one-cycle pulse the consumer must take or lose.
module step_debounce
    import cpu_clk_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          lvl_q;
    logic          lvl_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_q;
    logic          press_d;

    // cnt_q tracks how many consecutive samples have disagreed with the debounced level.
    always_comb begin
        lvl_d   = lvl_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != lvl_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                lvl_d   = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/cpu_step_controller.sv
// CPU clock-enable generator: halt / single-step / divided / full-rate run with breakpoint latch.
// Latency: cpu_en_o is registered, one cycle after the sampled mode, press or divider wrap.
// No backpressure: enables are issued unconditionally; the CPU must accept every one.
module cpu_step_controller
    import cpu_clk_pkg::*;
#(
    parameter int DIV_MAX         = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [1:0]  mode_i,
    input  logic        step_btn_i,
    input  logic        break_i,
    input  logic        clear_i,
    output logic        cpu_en_o,
    output logic        halted_o,
    output logic        brk_hit_o,
    output logic [31:0] step_cnt_o
);

    localparam int DW = $clog2(DIV_MAX);

    state_t        state_q;
    state_t        state_d;
    mode_t         mode_cur;
    mode_t         mode_q;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          cpu_en_q;
    logic          cpu_en_d;
    logic          brk_q;
    logic          brk_d;
    logic [31:0]   step_cnt_q;
    logic [31:0]   step_cnt_d;
    logic          press;

    step_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .btn_i  (step_btn_i),
        .press_o(press)
    );

    assign mode_cur = mode_t'(mode_i);

    // The divider defaults to zero so it restarts on entry, on mode change and outside SLOW.
    always_comb begin
        state_d  = state_q;
        div_d    = '0;
        cpu_en_d = 1'b0;
        brk_d    = brk_q;
        case (state_q)
            HALTED: begin
                if (mode_runs(mode_cur) && !brk_q) begin
                    state_d  = RUNNING;
                    cpu_en_d = (mode_cur == FAST);
                end else begin
                    cpu_en_d = press;
                end
            end
            RUNNING: begin
                if (break_i) begin
                    state_d = BREAK;
                    brk_d   = 1'b1;
                end else if (!mode_runs(mode_cur)) begin
                    state_d = HALTED;
                end else if (mode_cur == FAST) begin
                    cpu_en_d = 1'b1;
                end else if (mode_cur == mode_q) begin
                    if (div_q == DW'(DIV_MAX - 1)) begin
                        cpu_en_d = 1'b1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            BREAK: begin
                cpu_en_d = press;
                // A simultaneous break re-arms the latch, so clear only takes effect alone.
                if (clear_i && !break_i) begin
                    state_d = HALTED;
                    brk_d   = 1'b0;
                end
            end
            default: state_d = HALTED;
        endcase
        step_cnt_d = step_cnt_q + 32'(cpu_en_d);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HALTED;
            mode_q     <= HALT;
            div_q      <= '0;
            cpu_en_q   <= 1'b0;
            brk_q      <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_cur;
            div_q      <= div_d;
            cpu_en_q   <= cpu_en_d;
            brk_q      <= brk_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign cpu_en_o   = cpu_en_q;
    assign halted_o   = (state_q != RUNNING);
    assign brk_hit_o  = brk_q;
    assign step_cnt_o = step_cnt_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Scoreboard bench for cpu_step_controller with DIV_MAX=4, DEBOUNCE_CYCLES=3.
// Expected enable cycles and counts are queued at stimulus time and retired on each cpu_en_o.
module tb_cpu_step_controller;
    import cpu_clk_pkg::*;

    localparam int DIV = 4;
    localparam int DEB = 3;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic [1:0]  mode_i = HALT;
    logic        step_btn_i = 1'b0;
    logic        break_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        cpu_en_o;
    logic        halted_o;
    logic        brk_hit_o;
    logic [31:0] step_cnt_o;

    cpu_step_controller #(
        .DIV_MAX        (DIV),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .mode_i    (mode_i),
        .step_btn_i(step_btn_i),
        .break_i   (break_i),
        .clear_i   (clear_i),
        .cpu_en_o  (cpu_en_o),
        .halted_o  (halted_o),
        .brk_hit_o (brk_hit_o),
        .step_cnt_o(step_cnt_o)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          cyc;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] exp_cnt = '0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic push_en(input int at_cyc);
        exp_cnt = exp_cnt + 32'd1;
        sb.push_back('{at_cyc, exp_cnt});
    endtask

    // Every enable seen must match the oldest queued expectation, in cycle and count.
    always @(negedge clk_in) begin
        if (cpu_en_o) begin
            if (sb.size() == 0) begin
                check("en_spurious", 32'(cyc), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("en_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("step_cnt", step_cnt_o, mon_e.cnt);
            end
        end
    end

    initial begin
        int c;
        int s;

        #1;
        check("rst_en", 32'(cpu_en_o), 32'd0);
        check("rst_halted", 32'(halted_o), 32'd1);
        check("rst_brk", 32'(brk_hit_o), 32'd0);
        check("rst_cnt", step_cnt_o, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // FAST for 10 sampled cycles.
        c = cyc;
        mode_i = FAST;
        for (int i = 1; i <= 10; i++) push_en(c + i);
        tick(10);
        mode_i = HALT;
        tick(3);
        check("fast_missing", 32'(sb.size()), 32'd0);
        check("fast_cnt", step_cnt_o, 32'd10);

        // SLOW: pulses 4, 8, 12, 16 cycles after entry.
        c = cyc;
        mode_i = SLOW;
        for (int k = 1; k <= 4; k++) push_en(c + 1 + DIV * k);
        tick(1 + 4 * DIV);
        mode_i = HALT;
        tick(3);
        check("slow_missing", 32'(sb.size()), 32'd0);
        check("slow_cnt", step_cnt_o, 32'd14);

        // STEP with a one-cycle bounce before a 10-cycle hold.
        mode_i = STEP;
        tick(2);
        step_btn_i = 1'b1;
        check("step_halted", 32'(halted_o), 32'd1);
        tick();
        step_btn_i = 1'b0;
        check("step_halted", 32'(halted_o), 32'd1);
        tick();
        step_btn_i = 1'b1;
        s = cyc;
        push_en(s + 3 + DEB);
        for (int i = 0; i < 10; i++) begin
            check("step_halted", 32'(halted_o), 32'd1);
            tick();
        end
        step_btn_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("step_halted", 32'(halted_o), 32'd1);
            tick();
        end
        check("step_missing", 32'(sb.size()), 32'd0);
        check("step_cnt", step_cnt_o, 32'd15);

        // A press shorter than the debounce window yields nothing.
        step_btn_i = 1'b1;
        tick(DEB - 1);
        step_btn_i = 1'b0;
        tick(8);
        check("short_cnt", step_cnt_o, 32'd15);
        mode_i = HALT;
        tick(2);

        // Breakpoint while running FAST.
        c = cyc;
        mode_i = FAST;
        push_en(c + 1);
        push_en(c + 2);
        push_en(c + 3);
        tick(3);
        break_i = 1'b1;
        tick();
        break_i = 1'b0;
        check("brk_set", 32'(brk_hit_o), 32'd1);
        check("brk_halted", 32'(halted_o), 32'd1);
        tick(3);
        check("brk_hold", 32'(brk_hit_o), 32'd1);
        break_i = 1'b1;
        clear_i = 1'b1;
        tick();
        break_i = 1'b0;
        clear_i = 1'b0;
        check("brk_clr_race", 32'(brk_hit_o), 32'd1);
        check("brk_clr_race_halted", 32'(halted_o), 32'd1);

        // A step press is still honoured in BREAK.
        step_btn_i = 1'b1;
        s = cyc;
        push_en(s + 3 + DEB);
        tick(10);
        step_btn_i = 1'b0;
        tick(6);
        check("brk_step_missing", 32'(sb.size()), 32'd0);
        check("brk_after_step", 32'(brk_hit_o), 32'd1);

        // clear alone: back to HALTED, then RUNNING again since mode is still FAST.
        clear_i = 1'b1;
        c = cyc;
        tick();
        clear_i = 1'b0;
        check("clr_brk", 32'(brk_hit_o), 32'd0);
        check("clr_halted", 32'(halted_o), 32'd1);
        push_en(c + 2);
        push_en(c + 3);
        push_en(c + 4);
        tick();
        check("rerun_halted", 32'(halted_o), 32'd0);
        tick(2);
        mode_i = HALT;
        tick(3);
        check("rerun_missing", 32'(sb.size()), 32'd0);

        // Reset in the middle of a SLOW count.
        c = cyc;
        mode_i = SLOW;
        push_en(c + 1 + DIV);
        tick(7);
        rst_n = 1'b0;
        #1;
        check("mid_rst_en", 32'(cpu_en_o), 32'd0);
        check("mid_rst_halted", 32'(halted_o), 32'd1);
        check("mid_rst_brk", 32'(brk_hit_o), 32'd0);
        check("mid_rst_cnt", step_cnt_o, 32'd0);
        exp_cnt = '0;
        tick(2);
        rst_n = 1'b1;
        c = cyc;
        push_en(c + 1 + DIV);
        tick(2 + DIV);
        mode_i = HALT;
        tick(3);
        check("post_rst_missing", 32'(sb.size()), 32'd0);
        check("post_rst_cnt", step_cnt_o, 32'd1);

        // Counter wrap from all-ones.
        force dut.step_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.step_cnt_q;
        tick();
        check("preload", step_cnt_o, 32'hFFFF_FFFF);
        exp_cnt = 32'hFFFF_FFFF;
        c = cyc;
        mode_i = FAST;
        push_en(c + 1);
        tick();
        mode_i = HALT;
        tick(3);
        check("wrap_cnt", step_cnt_o, 32'd0);
        check("wrap_missing", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
